// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - two-port PSRAM controller arbiter with streak limit and watchdog
module psram_arbiter #(
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic        i_clk,
    input  logic        arst_n,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_we0,
    input  logic        i_we1,
    input  logic [23:0] i_addr0,
    input  logic [23:0] i_addr1,
    input  logic [15:0] i_wdata0,
    input  logic [15:0] i_wdata1,
    output logic        o_ack0,
    output logic        o_ack1,
    output logic [15:0] o_rdata,
    output logic        o_err,
    output logic        o_ready,
    output logic        o_stb,
    output logic        o_we,
    output logic [23:0] o_addr,
    output logic [15:0] o_din,
    input  logic        i_busy,
    input  logic        i_done,
    input  logic [15:0] i_dout
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_ACK
    } state_t;

    localparam logic [3:0]  STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [10:0] TIMEOUT_W  = 11'(TIMEOUT);

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic [3:0]  streak_q, streak_d;
    logic [9:0]  wd_q, wd_d;
    logic        stb_q, stb_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic [15:0] rdata_q, rdata_d;

    logic ctrl_idle, any_req, pick1, in_wait, wd_expire, done_hit, timeout_hit;

    assign ctrl_idle   = i_done && !i_busy;
    assign any_req     = i_req0 || i_req1;
    assign pick1       = i_req1 && (!i_req0 || (streak_q == STREAK_MAX));
    assign in_wait     = (state_q == S_WAIT_START) || (state_q == S_WAIT_DONE);
    // Deciding two counts early lands the ack exactly TIMEOUT cycles after the strobe.
    assign wd_expire   = ({1'b0, wd_q} + 11'd2) >= TIMEOUT_W;
    assign done_hit    = (state_q == S_WAIT_DONE) && ctrl_idle;
    assign timeout_hit = in_wait && wd_expire && !done_hit;

    always_ff @(posedge i_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_INIT;
            gnt_q    <= 1'b0;
            streak_q <= '0;
            wd_q     <= '0;
            stb_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            streak_q <= streak_d;
            wd_q     <= wd_d;
            stb_q    <= stb_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:       if (ctrl_idle) state_d = S_IDLE;
            S_IDLE:       if (any_req) state_d = S_ISSUE;
            S_ISSUE:      state_d = S_WAIT_START;
            // Waiting for busy keeps the previous transaction's done from looking like completion.
            S_WAIT_START: begin
                if (timeout_hit)  state_d = S_ACK;
                else if (i_busy)  state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE:  if (done_hit || timeout_hit) state_d = S_ACK;
            S_ACK:        state_d = S_IDLE;
            default:      state_d = S_INIT;
        endcase
    end

    always_comb begin
        gnt_d    = gnt_q;
        streak_d = streak_q;
        wd_d     = wd_q;
        err_d    = err_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        rdata_d  = rdata_q;
        stb_d    = (state_d == S_ISSUE);
        ready_d  = (state_d == S_IDLE);
        ack0_d   = (state_d == S_ACK) && !gnt_q;
        ack1_d   = (state_d == S_ACK) && gnt_q;

        if ((state_q == S_IDLE) && any_req) begin
            gnt_d = pick1;
            if (pick1) begin
                streak_d = '0;
                we_d     = i_we1;
                addr_d   = i_addr1;
                din_d    = i_wdata1;
            end else begin
                streak_d = i_req1 ? streak_q + 4'd1 : 4'd0;
                we_d     = i_we0;
                addr_d   = i_addr0;
                din_d    = i_wdata0;
            end
        end

        if (state_q == S_ISSUE) wd_d = '0;
        if (in_wait)            wd_d = wd_q + 10'd1;
        if (done_hit && !we_q)  rdata_d = i_dout;
        if (timeout_hit)        err_d = 1'b1;
    end

    assign o_stb   = stb_q;
    assign o_ack0  = ack0_q;
    assign o_ack1  = ack1_q;
    assign o_err   = err_q;
    assign o_ready = ready_q;
    assign o_we    = we_q;
    assign o_addr  = addr_q;
    assign o_din   = din_q;
    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// tb/tb_psram_arbiter.sv - directed bench for psram_arbiter with a small controller model
module tb_psram_arbiter;

    localparam int LAT = 16;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        i_req0 = 1'b0, i_req1 = 1'b0;
    logic        i_we0 = 1'b0, i_we1 = 1'b0;
    logic [23:0] i_addr0 = '0, i_addr1 = '0;
    logic [15:0] i_wdata0 = '0, i_wdata1 = '0;
    logic        o_ack0, o_ack1, o_err, o_ready, o_stb, o_we;
    logic [15:0] o_rdata, o_din;
    logic [23:0] o_addr;
    logic        busy = 1'b0, done = 1'b0;
    logic [15:0] dout = '0;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int stb_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, mcnt = 0;
    logic        ctrl_up = 1'b0, hang = 1'b0;
    logic [15:0] rval = '0;
    logic        in_flight = 1'b0, hold_bad = 1'b0;
    logic [23:0] snap_addr;
    logic [15:0] snap_din;
    logic        snap_we;
    int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    psram_arbiter #(.MAX_STREAK(4), .TIMEOUT(50)) dut (
        .i_clk(clk), .arst_n(arst_n),
        .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
        .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .o_ack0(o_ack0), .o_ack1(o_ack1), .o_rdata(o_rdata), .o_err(o_err),
        .o_ready(o_ready), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_din(o_din),
        .i_busy(busy), .i_done(done), .i_dout(dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: busy the cycle after the strobe, done LAT cycles later.
    always @(negedge clk) begin
        if (!ctrl_up) begin
            busy = 1'b0; done = 1'b0; mcnt = 0;
        end else if (o_stb) begin
            busy = 1'b1; done = 1'b0; mcnt = LAT;
        end else if (busy && !hang) begin
            if (mcnt <= 1) begin busy = 1'b0; done = 1'b1; dout = rval; end
            else mcnt = mcnt - 1;
        end else if (!busy) begin
            done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!arst_n) begin
            in_flight = 1'b0;
        end else begin
            if (o_stb) begin
                stb_cnt++; in_flight = 1'b1;
                snap_addr = o_addr; snap_din = o_din; snap_we = o_we;
            end
            if (in_flight && (o_addr !== snap_addr || o_din !== snap_din || o_we !== snap_we))
                hold_bad = 1'b1;
            if (o_ack0) ack0_cnt++;
            if (o_ack1) ack1_cnt++;
            if (o_ack0 || o_ack1) in_flight = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic hit(input int which);
        case (which)
            0:       return o_stb;
            1:       return o_ack0;
            2:       return o_ack1;
            default: return o_ack0 || o_ack1;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int budget, input string tag);
        logic seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (hit(which)) begin seen = 1'b1; break; end
        end
        if (!seen) check_eq({tag, " seen"}, 32'(seen), 32'd1);
    endtask

    task automatic ctrl_set(input logic up, input logic hg);
        @(posedge clk); #1;
        ctrl_up = up; hang = hg;
    endtask

    initial begin
        int t0, scnt, acnt;
        repeat (4) @(negedge clk);
        check_eq("rst stb",   32'(o_stb),   0);
        check_eq("rst ack0",  32'(o_ack0),  0);
        check_eq("rst ack1",  32'(o_ack1),  0);
        check_eq("rst err",   32'(o_err),   0);
        check_eq("rst ready", 32'(o_ready), 0);
        check_eq("rst we",    32'(o_we),    0);
        check_eq("rst addr",  32'(o_addr),  0);
        check_eq("rst din",   32'(o_din),   0);
        check_eq("rst rdata", 32'(o_rdata), 0);
        arst_n = 1'b1;

        // Init gating, then a single port-1 read.
        i_req1 = 1'b1; i_we1 = 1'b0; i_addr1 = 24'h00ABCD; rval = 16'hBEEF;
        repeat (200) @(negedge clk);
        #1 check_eq("init no stb", 32'(stb_cnt), 0);
        ctrl_set(1'b1, 1'b0);
        t0 = cyc;
        wait_sig(0, 20, "init stb");
        check_eq("init stb delay", 32'(cyc - t0), 2);
        wait_sig(2, 60, "read ack1");
        i_req1 = 1'b0;
        check_eq("read rdata", 32'(o_rdata), 32'hBEEF);
        check_eq("read addr",  32'(o_addr),  32'h00ABCD);
        repeat (3) @(negedge clk);
        #1;
        check_eq("read stb cnt",  32'(stb_cnt),  1);
        check_eq("read ack1 cnt", 32'(ack1_cnt), 1);
        check_eq("read ack0 cnt", 32'(ack0_cnt), 0);
        check_eq("read hold",     32'(hold_bad), 0);
        check_eq("idle ready",    32'(o_ready),  1);

        // Port-0 write.
        i_req0 = 1'b1; i_we0 = 1'b1; i_addr0 = 24'h000010; i_wdata0 = 16'h1234;
        wait_sig(1, 60, "write ack0");
        i_req0 = 1'b0;
        check_eq("write we",    32'(o_we),    1);
        check_eq("write din",   32'(o_din),   32'h1234);
        check_eq("write addr",  32'(o_addr),  32'h000010);
        check_eq("write rdata", 32'(o_rdata), 32'hBEEF);
        repeat (2) @(negedge clk);
        #1 check_eq("write hold", 32'(hold_bad), 0);

        // Both ports requesting continuously: streak limit of 4.
        rval = 16'h5A5A;
        i_we0 = 1'b0; i_addr0 = 24'h000100; i_we1 = 1'b0; i_addr1 = 24'h000200;
        i_req0 = 1'b1; i_req1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_sig(3, 80, "starve ack");
            check_eq($sformatf("grant %0d", i), 32'(o_ack1), 32'(exp_order[i]));
        end
        i_req0 = 1'b0; i_req1 = 1'b0;
        check_eq("starve rdata", 32'(o_rdata), 32'h5A5A);

        // Watchdog: the model never finishes.
        repeat (2) @(negedge clk);
        ctrl_set(1'b1, 1'b1);
        @(negedge clk);
        i_req1 = 1'b1; i_we1 = 1'b0; i_addr1 = 24'h000055;
        wait_sig(0, 20, "wd stb");
        t0 = cyc;
        wait_sig(2, 120, "wd ack1");
        i_req1 = 1'b0;
        check_eq("wd delay", 32'(cyc - t0), 50);
        check_eq("wd err",   32'(o_err),   1);
        check_eq("wd rdata", 32'(o_rdata), 32'h5A5A);
        rval = 16'h0C0C;
        ctrl_set(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 24'h000020;
        wait_sig(1, 80, "post-wd ack0");
        i_req0 = 1'b0;
        check_eq("post-wd rdata", 32'(o_rdata), 32'h0C0C);
        check_eq("post-wd err",   32'(o_err),   1);

        // Reset in the middle of a transaction.
        repeat (2) @(negedge clk);
        rval = 16'h7777;
        i_req0 = 1'b1; i_addr0 = 24'h000030;
        wait_sig(0, 20, "mid stb");
        repeat (5) @(negedge clk);
        #1 acnt = ack0_cnt;
        @(posedge clk); #1;
        arst_n = 1'b0; ctrl_up = 1'b0;
        @(negedge clk);
        check_eq("mid rst rdata", 32'(o_rdata), 0);
        check_eq("mid rst err",   32'(o_err),   0);
        check_eq("mid rst addr",  32'(o_addr),  0);
        check_eq("mid rst ack0",  32'(o_ack0),  0);
        check_eq("mid rst ready", 32'(o_ready), 0);
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        #1 scnt = stb_cnt;
        repeat (20) @(negedge clk);
        #1;
        check_eq("post-rst no stb", 32'(stb_cnt - scnt), 0);
        check_eq("post-rst no ack", 32'(ack0_cnt - acnt), 0);
        ctrl_set(1'b1, 1'b0);
        t0 = cyc;
        wait_sig(0, 20, "post-rst stb");
        check_eq("post-rst stb delay", 32'(cyc - t0), 2);
        wait_sig(1, 60, "post-rst ack0");
        i_req0 = 1'b0;
        check_eq("post-rst rdata", 32'(o_rdata), 32'h7777);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
